bcd4_stopwatch_disp: RTL

Consumes the divided slow clock from the clock-divider stage as a count-enable and maintains a 4-digit BCD up/down counter with run/stop and clear control. It drives a multiplexed 4-digit common-anode seven-segment display. The whole block runs on the fast system clock. tick_in is treated as data (edge-detected) and is never used as a clock.

---
 rtl/bcd4_stopwatch_disp.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/bcd4_stopwatch_disp.sv
// Four-digit BCD up/down stopwatch counter stepped by rising edges of a slow tick,
// with a registered, multiplexed common-anode seven-segment display scanner.
module bcd4_stopwatch_disp #(
  parameter int SCAN_DIV = 5000,
  parameter int DP_POS   = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        btn_run,
  input  logic        btn_clr,
  input  logic        up_dn,
  output logic [15:0] bcd,
  output logic        running,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic          DP_RST    = (DP_POS == 0) ? 1'b0 : 1'b1;

  // One decimal step across all four digits; bit 16 is the carry/borrow out (wrap).
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    logic [3:0]  dg;
    c = 1'b1;
    r = v;
    for (int i = 0; i < 4; i++) begin
      dg = v[4*i +: 4];
      if (!c) begin
        r[4*i +: 4] = dg;
      end else if (up) begin
        if (dg >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = dg + 4'd1;
          c           = 1'b0;
        end
      end else begin
        if (dg == 4'd0 || dg > 4'd9) begin
          r[4*i +: 4] = 4'd9;
          c           = 1'b1;
        end else begin
          r[4*i +: 4] = dg - 4'd1;
          c           = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  logic          tick_q,    tick_d;
  logic [15:0]   bcd_q,     bcd_d;
  logic          running_q, running_d;
  logic          wrap_q,    wrap_d;
  logic [CW-1:0] scan_q,    scan_d;
  logic [1:0]    sel_q,     sel_d;
  logic [3:0]    an_q,      an_d;
  logic [6:0]    seg_q,     seg_d;
  logic          dp_q,      dp_d;
  logic          tick_rise_s;
  logic [16:0]   step_s;
  logic [3:0]    digit_s;
  logic          lz1_s, lz2_s, lz3_s, blank_s;

  // Counter control: clear beats run toggle; a step uses running as it was before any toggle.
  always_comb begin
    tick_d      = tick_in;
    tick_rise_s = tick_in & ~tick_q;
    step_s      = bcd_step(bcd_q, up_dn);
    bcd_d       = bcd_q;
    running_d   = running_q;
    wrap_d      = 1'b0;
    if (btn_clr) begin
      bcd_d     = 16'h0000;
      running_d = 1'b0;
    end else begin
      if (tick_rise_s && running_q) begin
        bcd_d  = step_s[15:0];
        wrap_d = step_s[16];
      end else begin
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
      end
      running_d = btn_run ? ~running_q : running_q;
    end
  end

  // Free-running scan timer and digit select.
  always_comb begin
    scan_d = scan_q;
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = sel_q + 2'd1;
    end else begin
      scan_d = scan_q + CW'(1);
      sel_d  = sel_q;
    end
  end

  // Display decode from the current select, captured into the output registers.
  always_comb begin
    lz3_s = (bcd_q[15:12] == 4'd0);
    lz2_s = lz3_s && (bcd_q[11:8] == 4'd0);
    lz1_s = lz2_s && (bcd_q[7:4] == 4'd0);
    case (sel_q)
      2'd0:    begin digit_s = bcd_q[3:0];   blank_s = 1'b0;  end
      2'd1:    begin digit_s = bcd_q[7:4];   blank_s = lz1_s; end
      2'd2:    begin digit_s = bcd_q[11:8];  blank_s = lz2_s; end
      2'd3:    begin digit_s = bcd_q[15:12]; blank_s = lz3_s; end
      default: begin digit_s = 4'd0;         blank_s = 1'b0;  end
    endcase
    an_d = ~(4'b0001 << sel_q);
    if (BLANK_LZ != 0 && blank_s) begin
      seg_d = 7'b1111111;
    end else begin
      seg_d = seg_of(digit_s);
    end
    dp_d = ({30'd0, sel_q} == DP_POS) ? 1'b0 : 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q    <= 1'b0;
      bcd_q     <= 16'h0000;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      scan_q    <= '0;
      sel_q     <= 2'd0;
      an_q      <= 4'b1110;
      seg_q     <= 7'b1000000;
      dp_q      <= DP_RST;
    end else begin
      tick_q    <= tick_d;
      bcd_q     <= bcd_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      scan_q    <= scan_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign bcd     = bcd_q;
  assign running = running_q;
  assign wrap    = wrap_q;
  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;

endmodule
